mux_memoria_nx1: RTL and testbench

MUX_MEMORIA_NX1 -- requirements
Module: mux_memoria_nx1

---
 rtl/mux_memoria_nx1.sv | 136 +++++++++++++
 tb/tb_mux_memoria_nx1.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mux_memoria_nx1.sv
// Round-robin N:1 multiplexer with a small FIFO per input channel and a
// registered single-word output stage (EMPTY/HOLD) using valid/ready handshake.
module mux_memoria_nx1 #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 4,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       in_valid,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    output logic [CHANNELS-1:0]       in_full,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [WIDTH-1:0]          out_data,
    output logic [CW-1:0]             out_channel,
    output logic [CHANNELS-1:0]       overflow
);

    // state   | meaning
    // S_EMPTY | output register holds nothing, out_valid=0
    // S_HOLD  | output register holds a word awaiting out_ready
    typedef enum logic {S_EMPTY, S_HOLD} state_t;

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW = $clog2(DEPTH + 1);

    state_t state_q, state_d;

    logic [WIDTH-1:0]    mem    [CHANNELS][DEPTH];
    logic [PW-1:0]       rd_ptr [CHANNELS];
    logic [PW-1:0]       wr_ptr [CHANNELS];
    logic [NW-1:0]       count  [CHANNELS];
    logic [CHANNELS-1:0] nonempty;
    logic [CHANNELS-1:0] push;
    logic [CHANNELS-1:0] pop;
    logic [CHANNELS-1:0] full;
    logic [CW-1:0]       last_grant;
    logic [CW-1:0]       grant;
    logic                any_ne;
    logic                load;

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            full[i]     = (count[i] == NW'(DEPTH));
            nonempty[i] = (count[i] != '0);
            push[i]     = in_valid[i] && !full[i];
        end
    end

    assign in_full   = full;
    assign out_valid = (state_q == S_HOLD);

    // Scan downward so the last hit is the first non-empty channel after last_grant.
    always_comb begin
        int idx;
        grant  = '0;
        any_ne = 1'b0;
        idx    = 0;
        for (int k = CHANNELS; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % CHANNELS;
            if (nonempty[idx]) begin
                grant  = CW'(idx);
                any_ne = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        pop     = '0;
        case (state_q)
            S_EMPTY: begin
                if (any_ne) begin
                    load    = 1'b1;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    if (any_ne) load = 1'b1;
                    else        state_d = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
        if (load) pop[grant] = 1'b1;
    end

    // Storage needs no reset: counts at zero keep stale entries unreachable.
    always_ff @(posedge clk) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= in_data[i*WIDTH +: WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < CHANNELS; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            overflow <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PW'(1);
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PW'(1);
                if (push[i] && !pop[i])
                    count[i] <= count[i] + NW'(1);
                else if (!push[i] && pop[i])
                    count[i] <= count[i] - NW'(1);
                if (in_valid[i] && full[i]) overflow[i] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_EMPTY;
            out_data    <= '0;
            out_channel <= '0;
            last_grant  <= CW'(CHANNELS - 1);
        end else begin
            state_q <= state_d;
            if (load) begin
                out_data    <= mem[grant][rd_ptr[grant]];
                out_channel <= grant;
                last_grant  <= grant;
            end
        end
    end

endmodule

// File: tb/tb_mux_memoria_nx1.sv
// Scoreboard bench for mux_memoria_nx1 (WIDTH=8, CHANNELS=2, DEPTH=4): stimulus
// pushes expected {channel,data} words, a negedge monitor pops them on handshakes.
module tb_mux_memoria_nx1;
    localparam int WIDTH    = 8;
    localparam int CHANNELS = 2;
    localparam int DEPTH    = 4;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_full;
    logic                      out_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [0:0]                out_channel;
    logic [CHANNELS-1:0]       overflow;

    mux_memoria_nx1 #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_full(in_full), .out_ready(out_ready), .out_valid(out_valid),
        .out_data(out_data), .out_channel(out_channel), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [8:0] exp_q[$];
    logic [8:0] exp_item;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got ch%0d 0x%0h, expected no word", out_channel, out_data);
            end else begin
                exp_item = exp_q.pop_front();
                check("out_word{ch,data}", {23'd0, out_channel, out_data}, {23'd0, exp_item});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1);
        in_valid = v;
        in_data  = {d1, d0};
    endtask

    task automatic expect_word(input logic ch, input logic [7:0] d);
        exp_q.push_back({ch, d});
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check("drain_remaining_words", exp_q.size(), 0);
    endtask

    logic [8:0] seq_032 [8];

    initial begin
        seq_032 = '{9'h000, 9'h103, 9'h001, 9'h104, 9'h002, 9'h105, 9'h003, 9'h106};
        reset = 1'b1; in_valid = '0; in_data = '0; out_ready = 1'b0;

        // Reset held two cycles
        tick(); tick();
        check("reset_out_valid", out_valid, 0);
        check("reset_out_data", out_data, 8'h00);
        check("reset_in_full", in_full, 2'b00);
        check("reset_overflow", overflow, 2'b00);
        reset = 1'b0;

        // Both channels, round-robin interleave
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) exp_q.push_back(seq_032[i]);
        for (int k = 0; k < 4; k++) begin
            drive(2'b11, 8'(k), 8'(k + 3));
            tick();
        end
        drive(2'b00, 8'h00, 8'h00);
        drain(30);
        check("rr_overflow", overflow, 2'b00);
        check("rr_idle_out_valid", out_valid, 0);

        // Fill ch0 while stalled, overflow on the sixth word
        out_ready = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive(2'b01, 8'(8'h10 + k), 8'h00);
            if (k < 5) expect_word(1'b0, 8'(8'h10 + k));
            tick();
            if (k == 4) begin
                check("fill_in_full_at_0x14", in_full, 2'b01);
                check("fill_overflow_before_drop", overflow, 2'b00);
            end
        end
        drive(2'b00, 8'h00, 8'h00);
        check("stall_overflow", overflow, 2'b01);
        check("stall_in_full", in_full, 2'b01);
        check("stall_out_valid", out_valid, 1);
        check("stall_out_data", out_data, 8'h10);
        tick(); tick(); tick();
        check("stall_out_data_stable", out_data, 8'h10);
        check("stall_out_channel", out_channel, 0);
        out_ready = 1'b1;
        drain(30);
        check("fill_drained_out_valid", out_valid, 0);
        check("fill_drained_in_full", in_full, 2'b00);

        // Single channel streaming: no bypass, then no bubbles
        drive(2'b10, 8'h00, 8'h20);
        expect_word(1'b1, 8'h20);
        tick();
        check("stream_no_bypass", out_valid, 0);
        for (int k = 1; k < 6; k++) begin
            drive(2'b10, 8'h00, 8'(8'h20 + k));
            expect_word(1'b1, 8'(8'h20 + k));
            tick();
            check("stream_out_valid", out_valid, 1);
            check("stream_out_channel", out_channel, 1);
        end
        drive(2'b00, 8'h00, 8'h00);
        tick();
        check("stream_last_out_valid", out_valid, 1);
        check("stream_last_out_data", out_data, 8'h25);
        tick();
        check("stream_end_out_valid", out_valid, 0);
        check("stream_queue_empty", exp_q.size(), 0);

        // Sticky overflow across 20 cycles of traffic
        for (int k = 0; k < 20; k++) begin
            drive(2'b01, 8'(8'h80 + k), 8'h00);
            expect_word(1'b0, 8'(8'h80 + k));
            tick();
            check("sticky_overflow", overflow, 2'b01);
        end
        drive(2'b00, 8'h00, 8'h00);
        drain(30);
        check("sticky_overflow_after", overflow, 2'b01);

        // Reset with words buffered and output held
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive((k < 3) ? 2'b11 : 2'b10, 8'(8'hA0 + k), 8'(8'hB0 + k));
            tick();
        end
        drive(2'b00, 8'h00, 8'h00);
        check("prereset_out_valid", out_valid, 1);
        check("prereset_overflow", overflow, 2'b01);
        reset = 1'b1;
        tick();
        check("midreset_out_valid", out_valid, 0);
        check("midreset_in_full", in_full, 2'b00);
        check("midreset_overflow", overflow, 2'b00);
        check("midreset_out_data", out_data, 8'h00);
        reset = 1'b0;
        out_ready = 1'b1;
        tick();
        check("postreset_idle", out_valid, 0);
        drive(2'b11, 8'h50, 8'h60);
        expect_word(1'b0, 8'h50);
        expect_word(1'b1, 8'h60);
        tick();
        drive(2'b00, 8'h00, 8'h00);
        drain(30);
        tick();
        check("postreset_final_out_valid", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
